// File: rtl/bp_pkg.sv
// Shared types and constants for the branch direction predictor.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam int unsigned BP_IDX_W = 6;
    localparam int unsigned MP_CNT_W = 16;

    // The direction is the counter MSB: WT and ST predict taken.
    function automatic logic ctr_taken(input ctr_t c);
        return (c == WT) || (c == ST);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state for one 2-bit saturating direction counter.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_t cur,
    input  logic taken,
    output ctr_t nxt
);

    always_comb begin
        nxt = cur;
        unique case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Table of 2-bit counters predicting branch direction at fetch, trained at execute.
// Optional same-cycle update-to-fetch forwarding is enabled by defining BP_BYPASS_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = BP_IDX_W,
    parameter int unsigned PC_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_valid,
    input  logic [PC_W-1:0]     fetch_pc,
    output logic                pred_taken,
    input  logic                upd_valid,
    input  logic [PC_W-1:0]     upd_pc,
    input  logic                upd_taken,
    input  logic                upd_pred,
    output logic                mispredict,
    output logic [MP_CNT_W-1:0] mp_count
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    logic [IDX_W-1:0]    fetch_idx;
    logic [IDX_W-1:0]    upd_idx;
    ctr_t                table_q [ENTRIES];
    ctr_t                table_d [ENTRIES];
    ctr_t                upd_cur;
    ctr_t                upd_nxt;
    logic                mp_now;
    logic                mispredict_d, mispredict_q;
    logic [MP_CNT_W-1:0] mp_count_d, mp_count_q;

    // Word-aligned PCs: low two bits and everything above the index are untagged.
    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign upd_idx   = upd_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    assign upd_cur = table_q[upd_idx];

    sat_counter2 u_upd_ctr (
        .cur   (upd_cur),
        .taken (upd_taken),
        .nxt   (upd_nxt)
    );

    always_comb begin
        table_d = table_q;
        if (upd_valid) begin
            table_d[upd_idx] = upd_nxt;
        end
    end

    always_comb begin
        pred_taken = 1'b0;
        if (fetch_valid) begin
            pred_taken = ctr_taken(table_q[fetch_idx]);
`ifdef BP_BYPASS_EN
            if (upd_valid && (upd_idx == fetch_idx)) begin
                pred_taken = ctr_taken(upd_nxt);
            end
`endif
        end
    end

    always_comb begin
        mp_now       = upd_valid & (upd_taken ^ upd_pred);
        mispredict_d = mp_now;
        mp_count_d   = mp_count_q;
        if (mp_now && (mp_count_q != '1)) begin
            mp_count_d = mp_count_q + MP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= WNT;
            end
            mispredict_q <= 1'b0;
            mp_count_q   <= '0;
        end else begin
            table_q      <= table_d;
            mispredict_q <= mispredict_d;
            mp_count_q   <= mp_count_d;
        end
    end

    assign mispredict = mispredict_q;
    assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against an integer-array reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        pred_taken;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred = 1'b0;
    logic        mispredict;
    logic [15:0] mp_count;

    int n_checks = 0;
    int n_fail   = 0;

    int ctr [64];
    int mp_cnt;
    bit mp_prev;

    branch_predictor #(.IDX_W(6), .PC_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .pred_taken  (pred_taken),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_pred    (upd_pred),
        .mispredict  (mispredict),
        .mp_count    (mp_count)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic void model_reset();
        foreach (ctr[i]) ctr[i] = 1;
        mp_cnt  = 0;
        mp_prev = 0;
    endfunction

    function automatic int model_next(input int c, input bit t);
        if (t) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    // Prediction as seen combinationally at fetch in the current cycle.
    function automatic bit model_pred();
        int fi;
        if (!fetch_valid) return 0;
        fi = idx_of(fetch_pc);
`ifdef BP_BYPASS_EN
        if (upd_valid && idx_of(upd_pc) == fi) return model_next(ctr[fi], upd_taken) >= 2;
`endif
        return ctr[fi] >= 2;
    endfunction

    // Advance one clock, applying whatever update is on the inputs, and settle 1ns later.
    task automatic clock_cycle();
        @(posedge clk);
        if (upd_valid) begin
            ctr[idx_of(upd_pc)] = model_next(ctr[idx_of(upd_pc)], upd_taken);
            mp_prev = (upd_taken != upd_pred);
            if (mp_prev && mp_cnt < 65535) mp_cnt++;
        end else begin
            mp_prev = 0;
        end
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input bit t, input bit p);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_pred = p;
        clock_cycle();
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        fetch_valid = 1'b1; fetch_pc = 32'h0040_0000;
        #3;
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred: got %b want 0", pred_taken); end
        n_checks++;
        if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
        n_checks++;
        if (mp_count !== 16'h0) begin n_fail++; $display("FAIL reset_mp_count: got %h want 0000", mp_count); end
        #4 rst_n = 1'b1;
        clock_cycle();
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL post_reset_pred: got %b want 0", pred_taken); end
    endtask

    task automatic test_training();
        logic [31:0] pc = 32'h0040_0010;
        fetch_valid = 1'b1; fetch_pc = pc;
        for (int k = 0; k < 2; k++) begin
            do_update(pc, 1'b1, 1'b0);
            n_checks++;
            if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_pred[%0d]: got %b want 1", k, pred_taken); end
            n_checks++;
            if (mispredict !== 1'b1) begin n_fail++; $display("FAIL train_mp_pulse[%0d]: got %b want 1", k, mispredict); end
        end
        n_checks++;
        if (ctr[idx_of(pc)] != 3) begin n_fail++; $display("FAIL train_model_state: got %0d want 3", ctr[idx_of(pc)]); end
        clock_cycle();
        n_checks++;
        if (mispredict !== 1'b0) begin n_fail++; $display("FAIL train_mp_end: got %b want 0", mispredict); end
        n_checks++;
        if (mp_count !== 16'd2) begin n_fail++; $display("FAIL train_mp_count: got %0d want 2", mp_count); end
    endtask

    task automatic test_saturation();
        logic [31:0] pc = 32'h0040_0010;
        fetch_valid = 1'b1; fetch_pc = pc;
        for (int k = 0; k < 5; k++) do_update(pc, 1'b1, 1'b1);
        do_update(pc, 1'b0, 1'b1);
        n_checks++;
        if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_wt_pred: got %b want 1", pred_taken); end
        n_checks++;
        if (mispredict !== 1'b1) begin n_fail++; $display("FAIL sat_nt_mp: got %b want 1", mispredict); end
        do_update(pc, 1'b0, 1'b1);
        do_update(pc, 1'b0, 1'b0);
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_snt_pred: got %b want 0", pred_taken); end
        do_update(pc, 1'b0, 1'b0);
        do_update(pc, 1'b1, 1'b0);
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_snt_floor: got %b want 0", pred_taken); end
        n_checks++;
        if (mp_count !== 16'(mp_cnt)) begin n_fail++; $display("FAIL sat_mp_count: got %0d want %0d", mp_count, mp_cnt); end
    endtask

    task automatic test_alias();
        do_update(32'h0000_0100, 1'b1, 1'b0);
        do_update(32'h0000_0100, 1'b1, 1'b0);
        fetch_valid = 1'b1; fetch_pc = 32'h0000_0200;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_pred: got %b want 1", pred_taken); end
        fetch_pc = 32'h0000_0104;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL isolation_pred: got %b want 0", pred_taken); end
        fetch_valid = 1'b0; fetch_pc = 32'h0000_0100;
        #1;
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL fetch_invalid_pred: got %b want 0", pred_taken); end
    endtask

    task automatic test_collision();
        bit exp_now;
`ifdef BP_BYPASS_EN
        exp_now = 1'b1;
`else
        exp_now = 1'b0;
`endif
        fetch_valid = 1'b1; fetch_pc = 32'h0000_0020;
        upd_valid = 1'b1; upd_pc = 32'h0000_0020; upd_taken = 1'b1; upd_pred = 1'b0;
        #1;
        n_checks++;
        if (pred_taken !== exp_now) begin n_fail++; $display("FAIL collision_same_cycle: got %b want %b", pred_taken, exp_now); end
        clock_cycle();
        upd_valid = 1'b0;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL collision_next_cycle: got %b want 1", pred_taken); end
    endtask

    task automatic test_random();
        logic [31:0] pcs [8];
        bit exp_p;
        foreach (pcs[i]) pcs[i] = 32'(i * 4 + (i % 2) * 256 + 32'h0000_1000);
        for (int k = 0; k < 400; k++) begin
            fetch_valid = 1'($urandom_range(0, 1));
            fetch_pc    = pcs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            upd_valid   = 1'($urandom_range(0, 1));
            upd_pc      = pcs[$urandom_range(0, 7)];
            upd_taken   = 1'($urandom_range(0, 1));
            upd_pred    = 1'($urandom_range(0, 1));
            #1;
            exp_p = model_pred();
            n_checks++;
            if (pred_taken !== exp_p) begin n_fail++; $display("FAIL rand_pred[%0d]: got %b want %b", k, pred_taken, exp_p); end
            clock_cycle();
            n_checks++;
            if (mispredict !== mp_prev) begin n_fail++; $display("FAIL rand_mp[%0d]: got %b want %b", k, mispredict, mp_prev); end
            n_checks++;
            if (mp_count !== 16'(mp_cnt)) begin n_fail++; $display("FAIL rand_mp_count[%0d]: got %0d want %0d", k, mp_count, mp_cnt); end
        end
        upd_valid = 1'b0;
    endtask

    task automatic test_mp_saturate_and_reset();
        bit bad;
        upd_valid = 1'b1; upd_pc = 32'h0000_0040; upd_taken = 1'b1; upd_pred = 1'b0;
        for (int k = 0; k < 65540; k++) clock_cycle();
        n_checks++;
        if (mp_count !== 16'hFFFF || mp_cnt != 65535) begin n_fail++; $display("FAIL mp_count_saturate: got %h want FFFF", mp_count); end
        n_checks++;
        if (mispredict !== 1'b1) begin n_fail++; $display("FAIL mp_pulse_stream: got %b want 1", mispredict); end
        // Mid-cycle asynchronous reset while an update is still on the inputs.
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mp_count !== 16'h0) begin n_fail++; $display("FAIL async_reset_mp_count: got %h want 0000", mp_count); end
        n_checks++;
        if (mispredict !== 1'b0) begin n_fail++; $display("FAIL async_reset_mispredict: got %b want 0", mispredict); end
        upd_valid = 1'b0;
        fetch_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            fetch_pc = 32'(i * 4);
            #1;
            if (pred_taken !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL async_reset_table: some entry got 1 want all 0"); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        fetch_pc = 32'h0000_0040;
        do_update(32'h0000_0040, 1'b1, 1'b1);
        n_checks++;
        if (pred_taken !== 1'b1 || mispredict !== 1'b0) begin
            n_fail++; $display("FAIL first_edge_after_reset: got pred=%b mp=%b want pred=1 mp=0", pred_taken, mispredict);
        end
    endtask

    initial begin
        test_reset();
        test_training();
        test_saturation();
        test_alias();
        test_collision();
        test_random();
        test_mp_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
